tcp_session_responder: RTL and testbench

TCP_SESSION_RESPONDER -- requirements
Module: tcp_session_responder

---
 rtl/tcp_session_responder.sv | 215 +++++++++++++++++++++
 tb/tb_tcp_session_responder.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_session_responder.sv
// TCP session responder: hands out session IDs from a bitmap pool, issues a
// connect command to the stack, waits (with timeout) for the establishment
// status and answers the requester. Close requests release pool entries.
module tcp_session_responder #(
   parameter int unsigned SID_BITS       = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                aclk,
   input  logic                aresetn,
   // open request from the application
   input  logic                s_open_req_valid,
   output logic                s_open_req_ready,
   input  logic [31:0]         s_open_req_ip_address,
   input  logic [15:0]         s_open_req_ip_port,
   // close request from the application
   input  logic                s_close_req_valid,
   output logic                s_close_req_ready,
   input  logic [SID_BITS-1:0] s_close_req_sid,
   // connect command towards the TCP stack
   output logic                m_conn_valid,
   input  logic                m_conn_ready,
   output logic [SID_BITS-1:0] m_conn_sid,
   output logic [31:0]         m_conn_ip_address,
   output logic [15:0]         m_conn_ip_port,
   // establishment status from the TCP stack
   input  logic                s_est_valid,
   output logic                s_est_ready,
   input  logic [SID_BITS-1:0] s_est_sid,
   input  logic                s_est_success,
   // open response to the application
   output logic                m_open_rsp_valid,
   input  logic                m_open_rsp_ready,
   output logic [SID_BITS-1:0] m_open_rsp_sid,
   output logic                m_open_rsp_success,
   // status
   output logic [SID_BITS:0]   active_cnt,
   output logic                close_err
);

   localparam int unsigned NumSess = 1 << SID_BITS;
   localparam logic [19:0] TmoLast = 20'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAlloc,
      StConn,
      StWaitEst,
      StRsp,
      StClose
   } state_t;

   state_t              r_state;
   logic [NumSess-1:0]  r_bitmap;
   logic [SID_BITS:0]   r_active_cnt;
   logic [19:0]         r_tmo_cnt;
   logic [SID_BITS-1:0] r_cur_sid;
   logic [SID_BITS-1:0] r_close_sid;
   logic [31:0]         r_ip;
   logic [15:0]         r_port;
   logic                r_conn_valid;
   logic                r_est_ready;
   logic                r_rsp_valid;
   logic [SID_BITS-1:0] r_rsp_sid;
   logic                r_rsp_success;
   logic                r_close_err;

   logic                w_idle;
   logic                w_free_found;
   logic [SID_BITS-1:0] w_free_idx;
   logic                w_est_match;
   logic                w_tmo;

   // Readies depend on the incoming valids so close can win over open in the
   // same cycle; gated by reset so they read 0 while the block is held.
   always_comb begin
      w_idle            = (r_state == StIdle) && aresetn;
      s_close_req_ready = w_idle;
      s_open_req_ready  = w_idle && !s_close_req_valid;
   end

   // Lowest-index free pool entry (scan from the top so the lowest wins)
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = int'(NumSess) - 1; i >= 0; i--) begin
         if (!r_bitmap[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = SID_BITS'(i);
         end
      end
   end

   // Establishment beat for the session in flight, and timeout expiry
   always_comb begin
      w_est_match = s_est_valid && r_est_ready && (s_est_sid == r_cur_sid);
      w_tmo       = (r_tmo_cnt == TmoLast);
   end

   // Session FSM with pool bitmap, counter and all registered outputs
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state       <= StIdle;
         r_bitmap      <= '0;
         r_active_cnt  <= '0;
         r_tmo_cnt     <= '0;
         r_cur_sid     <= '0;
         r_close_sid   <= '0;
         r_ip          <= '0;
         r_port        <= '0;
         r_conn_valid  <= 1'b0;
         r_est_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_sid     <= '0;
         r_rsp_success <= 1'b0;
         r_close_err   <= 1'b0;
      end else begin
         r_close_err <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (s_close_req_valid) begin
                  r_close_sid <= s_close_req_sid;
                  r_state     <= StClose;
               end else if (s_open_req_valid) begin
                  r_ip    <= s_open_req_ip_address;
                  r_port  <= s_open_req_ip_port;
                  r_state <= StAlloc;
               end
            end

            StAlloc: begin
               if (w_free_found) begin
                  r_bitmap[w_free_idx] <= 1'b1;
                  r_cur_sid            <= w_free_idx;
                  r_active_cnt         <= r_active_cnt + 1'b1;
                  r_conn_valid         <= 1'b1;
                  r_state              <= StConn;
               end else begin
                  // Pool exhausted: refuse without talking to the stack
                  r_rsp_sid     <= '0;
                  r_rsp_success <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= StRsp;
               end
            end

            StConn: begin
               if (m_conn_ready) begin
                  r_conn_valid <= 1'b0;
                  r_tmo_cnt    <= '0;
                  r_est_ready  <= 1'b1;
                  r_state      <= StWaitEst;
               end
            end

            StWaitEst: begin
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
               // A matching beat beats the timeout in the expiry cycle
               if (w_est_match) begin
                  if (!s_est_success) begin
                     r_bitmap[r_cur_sid] <= 1'b0;
                     r_active_cnt        <= r_active_cnt - 1'b1;
                  end
                  r_rsp_sid     <= r_cur_sid;
                  r_rsp_success <= s_est_success;
                  r_rsp_valid   <= 1'b1;
                  r_est_ready   <= 1'b0;
                  r_state       <= StRsp;
               end else if (w_tmo) begin
                  r_bitmap[r_cur_sid] <= 1'b0;
                  r_active_cnt        <= r_active_cnt - 1'b1;
                  r_rsp_sid           <= r_cur_sid;
                  r_rsp_success       <= 1'b0;
                  r_rsp_valid         <= 1'b1;
                  r_est_ready         <= 1'b0;
                  r_state             <= StRsp;
               end
            end

            StRsp: begin
               if (m_open_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end

            StClose: begin
               if (r_bitmap[r_close_sid]) begin
                  r_bitmap[r_close_sid] <= 1'b0;
                  r_active_cnt          <= r_active_cnt - 1'b1;
               end else begin
                  r_close_err <= 1'b1;
               end
               r_state <= StIdle;
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   // Output wiring
   always_comb begin
      m_conn_valid       = r_conn_valid;
      m_conn_sid         = r_cur_sid;
      m_conn_ip_address  = r_ip;
      m_conn_ip_port     = r_port;
      s_est_ready        = r_est_ready;
      m_open_rsp_valid   = r_rsp_valid;
      m_open_rsp_sid     = r_rsp_sid;
      m_open_rsp_success = r_rsp_success;
      active_cnt         = r_active_cnt;
      close_err          = r_close_err;
   end

endmodule

// File: tb/tb_tcp_session_responder.sv
// Self-checking bench for tcp_session_responder: directed scenarios plus a
// randomized open/close mix checked against a simple pool model.
module tb_tcp_session_responder;

   localparam int NumSess = 64;
   localparam int Tmo     = 16;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        s_open_req_valid = 1'b0;
   logic        s_open_req_ready;
   logic [31:0] s_open_req_ip_address = '0;
   logic [15:0] s_open_req_ip_port = '0;
   logic        s_close_req_valid = 1'b0;
   logic        s_close_req_ready;
   logic [5:0]  s_close_req_sid = '0;
   logic        m_conn_valid;
   logic        m_conn_ready = 1'b1;
   logic [5:0]  m_conn_sid;
   logic [31:0] m_conn_ip_address;
   logic [15:0] m_conn_ip_port;
   logic        s_est_valid = 1'b0;
   logic        s_est_ready;
   logic [5:0]  s_est_sid = '0;
   logic        s_est_success = 1'b0;
   logic        m_open_rsp_valid;
   logic        m_open_rsp_ready = 1'b1;
   logic [5:0]  m_open_rsp_sid;
   logic        m_open_rsp_success;
   logic [6:0]  active_cnt;
   logic        close_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: which sessions are handed out and how many
   bit model_alloc [NumSess];
   int model_cnt;

   tcp_session_responder #(
      .SID_BITS      (6),
      .TIMEOUT_CYCLES(Tmo)
   ) u_dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .s_open_req_valid     (s_open_req_valid),
      .s_open_req_ready     (s_open_req_ready),
      .s_open_req_ip_address(s_open_req_ip_address),
      .s_open_req_ip_port   (s_open_req_ip_port),
      .s_close_req_valid    (s_close_req_valid),
      .s_close_req_ready    (s_close_req_ready),
      .s_close_req_sid      (s_close_req_sid),
      .m_conn_valid         (m_conn_valid),
      .m_conn_ready         (m_conn_ready),
      .m_conn_sid           (m_conn_sid),
      .m_conn_ip_address    (m_conn_ip_address),
      .m_conn_ip_port       (m_conn_ip_port),
      .s_est_valid          (s_est_valid),
      .s_est_ready          (s_est_ready),
      .s_est_sid            (s_est_sid),
      .s_est_success        (s_est_success),
      .m_open_rsp_valid     (m_open_rsp_valid),
      .m_open_rsp_ready     (m_open_rsp_ready),
      .m_open_rsp_sid       (m_open_rsp_sid),
      .m_open_rsp_success   (m_open_rsp_success),
      .active_cnt           (active_cnt),
      .close_err            (close_err)
   );

   always #5 aclk = ~aclk;

   function automatic int model_lowest_free();
      for (int i = 0; i < NumSess; i++) begin
         if (!model_alloc[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NumSess; i++) model_alloc[i] = 1'b0;
      model_cnt = 0;
   endfunction

   function automatic bit outputs_zero();
      return ({m_conn_valid, s_est_ready, m_open_rsp_valid, s_close_req_ready,
               close_err, m_open_rsp_success} == 6'd0) && (m_conn_sid == 6'd0) &&
             (m_conn_ip_address == 32'd0) && (m_conn_ip_port == 16'd0) &&
             (m_open_rsp_sid == 6'd0) && (active_cnt == 7'd0);
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      #2;
      aresetn           = 1'b0;
      s_open_req_valid  = 1'b0;
      s_close_req_valid = 1'b0;
      s_est_valid       = 1'b0;
      m_conn_ready      = 1'b1;
      m_open_rsp_ready  = 1'b1;
      model_clear();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      tick();
   endtask

   // Present an open request and wait for its acceptance edge
   task automatic accept_open(input logic [31:0] ip, input logic [15:0] port, output bit got);
      s_open_req_valid      = 1'b1;
      s_open_req_ip_address = ip;
      s_open_req_ip_port    = port;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge aclk);
         got = s_open_req_ready;
         tick();
      end
      s_open_req_valid = 1'b0;
   endtask

   // mode: 0 est success, 1 est failure, 2 stack silent, 3 foreign beat then success
   task automatic run_open(input logic [31:0] ip, input logic [15:0] port, input int mode,
                           input int conn_stall);
      int         exp_sid;
      logic [5:0] exp_sid_l;
      bit         exp_ok;
      bit         got;
      bit         bad_conn;
      int         cnt;
      exp_sid   = model_lowest_free();
      exp_sid_l = (exp_sid < 0) ? 6'd0 : 6'(exp_sid);
      exp_ok    = (exp_sid >= 0) && (mode == 0 || mode == 3);
      m_conn_ready = (conn_stall == 0);
      accept_open(ip, port, got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL open_accept: ready=%0d required 1", s_open_req_ready);
         m_conn_ready = 1'b1;
         return;
      end
      if (exp_sid < 0) begin
         cnt      = 0;
         bad_conn = 1'b0;
         while (!m_open_rsp_valid && cnt < 10) begin
            if (m_conn_valid) bad_conn = 1'b1;
            tick();
            cnt++;
         end
         n_tests++;
         if (bad_conn || m_conn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_conn: conn beat seen=%0d required 0", 1);
         end
      end else begin
         n_tests++;
         if (m_conn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL conn_latency_early: m_conn_valid=%0d required 0", m_conn_valid);
         end
         tick();
         n_tests++;
         if (m_conn_valid !== 1'b1 || m_conn_sid !== exp_sid_l || m_conn_ip_address !== ip ||
             m_conn_ip_port !== port) begin
            n_fail++;
            $display("FAIL conn_payload: valid=%0d sid=%0d ip=%h port=%0d required 1 %0d %h %0d",
                     m_conn_valid, m_conn_sid, m_conn_ip_address, m_conn_ip_port, exp_sid_l, ip,
                     port);
         end
         for (int k = 0; k < conn_stall; k++) begin
            tick();
            n_tests++;
            if (m_conn_valid !== 1'b1 || m_conn_sid !== exp_sid_l || m_conn_ip_address !== ip) begin
               n_fail++;
               $display("FAIL conn_hold: valid=%0d sid=%0d required 1 %0d", m_conn_valid,
                        m_conn_sid, exp_sid_l);
            end
         end
         m_conn_ready = 1'b1;
         tick();
         n_tests++;
         if (s_est_ready !== 1'b1 || m_conn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_est_entry: est_ready=%0d conn_valid=%0d required 1 0", s_est_ready,
                     m_conn_valid);
         end
         if (mode == 3) begin
            s_est_valid   = 1'b1;
            s_est_sid     = exp_sid_l ^ 6'($urandom_range(1, 63));
            s_est_success = 1'b1;
            tick();
            s_est_valid = 1'b0;
            n_tests++;
            if (m_open_rsp_valid !== 1'b0 || s_est_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL foreign_est_drop: rsp_valid=%0d est_ready=%0d required 0 1",
                        m_open_rsp_valid, s_est_ready);
            end
         end
         if (mode == 2) begin
            cnt = 0;
            while (!m_open_rsp_valid && cnt < 3 * Tmo) begin
               tick();
               cnt++;
            end
            n_tests++;
            if (cnt != Tmo) begin
               n_fail++;
               $display("FAIL timeout_latency: cycles=%0d required %0d", cnt, Tmo);
            end
         end else begin
            s_est_valid   = 1'b1;
            s_est_sid     = exp_sid_l;
            s_est_success = (mode != 1);
            tick();
            s_est_valid = 1'b0;
            n_tests++;
            if (m_open_rsp_valid !== 1'b1 || s_est_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL rsp_latency: rsp_valid=%0d est_ready=%0d required 1 0",
                        m_open_rsp_valid, s_est_ready);
            end
         end
      end
      n_tests++;
      if (m_open_rsp_valid !== 1'b1 || m_open_rsp_sid !== exp_sid_l ||
          m_open_rsp_success !== exp_ok) begin
         n_fail++;
         $display("FAIL open_rsp: valid=%0d sid=%0d ok=%0d required 1 %0d %0d", m_open_rsp_valid,
                  m_open_rsp_sid, m_open_rsp_success, exp_sid_l, exp_ok);
      end
      if (exp_ok) begin
         model_alloc[exp_sid] = 1'b1;
         model_cnt++;
      end
      tick();
      n_tests++;
      if (m_open_rsp_valid !== 1'b0 || active_cnt !== 7'(model_cnt)) begin
         n_fail++;
         $display("FAIL after_rsp: rsp_valid=%0d active_cnt=%0d required 0 %0d",
                  m_open_rsp_valid, active_cnt, model_cnt);
      end
   endtask

   task automatic run_close(input int sid);
      bit exp_err;
      bit got;
      exp_err           = !model_alloc[sid];
      s_close_req_valid = 1'b1;
      s_close_req_sid   = 6'(sid);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge aclk);
         got = s_close_req_ready;
         tick();
      end
      s_close_req_valid = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL close_accept: ready=%0d required 1", s_close_req_ready);
         return;
      end
      tick();
      if (!exp_err) begin
         model_alloc[sid] = 1'b0;
         model_cnt--;
      end
      n_tests++;
      if (close_err !== exp_err || active_cnt !== 7'(model_cnt) || s_close_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL close_result sid=%0d: err=%0d cnt=%0d ready=%0d required %0d %0d 1", sid,
                  close_err, active_cnt, s_close_req_ready, exp_err, model_cnt);
      end
      tick();
      n_tests++;
      if (close_err !== 1'b0) begin
         n_fail++;
         $display("FAIL close_err_pulse: close_err=%0d required 0", close_err);
      end
   endtask

   task automatic test_reset();
      @(negedge aclk);
      #2;
      aresetn          = 1'b0;
      s_open_req_valid = 1'b1;
      #1;
      n_tests++;
      if (!outputs_zero() || s_open_req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: open_ready=%0d active_cnt=%0d required 0 0",
                  s_open_req_ready, active_cnt);
      end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      n_tests++;
      if (s_open_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_release: open_ready=%0d required 1", s_open_req_ready);
      end
      tick();
      s_open_req_valid = 1'b0;
      n_tests++;
      if (s_open_req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL first_edge_accept: open_ready=%0d required 0", s_open_req_ready);
      end
      apply_reset();
   endtask

   task automatic test_basic_open();
      apply_reset();
      run_open(32'h0A00_0001, 16'd80, 0, 0);
      n_tests++;
      if (active_cnt !== 7'd1) begin
         n_fail++;
         $display("FAIL basic_active_cnt: active_cnt=%0d required 1", active_cnt);
      end
   endtask

   task automatic test_pool_full();
      apply_reset();
      for (int i = 0; i < NumSess; i++) run_open($urandom, 16'($urandom), 0, 0);
      run_open(32'hC0A8_0001, 16'd443, 0, 0);
      n_tests++;
      if (active_cnt !== 7'd64) begin
         n_fail++;
         $display("FAIL full_active_cnt: active_cnt=%0d required 64", active_cnt);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      run_open(32'h0A00_0002, 16'd22, 2, 0);
      run_open(32'h0A00_0003, 16'd23, 0, 0);
   endtask

   task automatic test_close_priority();
      apply_reset();
      s_open_req_valid      = 1'b1;
      s_open_req_ip_address = 32'h0A00_0009;
      s_open_req_ip_port    = 16'd8080;
      s_close_req_valid     = 1'b1;
      s_close_req_sid       = 6'd3;
      @(negedge aclk);
      n_tests++;
      if (s_close_req_ready !== 1'b1 || s_open_req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL close_priority: close_ready=%0d open_ready=%0d required 1 0",
                  s_close_req_ready, s_open_req_ready);
      end
      tick();
      s_close_req_valid = 1'b0;
      s_open_req_valid  = 1'b0;
      tick();
      n_tests++;
      if (close_err !== 1'b1 || active_cnt !== 7'd0) begin
         n_fail++;
         $display("FAIL priority_close_err: close_err=%0d cnt=%0d required 1 0", close_err,
                  active_cnt);
      end
      run_open(32'h0A00_0009, 16'd8080, 0, 0);
   endtask

   task automatic test_reuse();
      apply_reset();
      for (int i = 0; i < 3; i++) run_open(32'h0A00_0010 + i, 16'd1000, 0, 0);
      run_close(1);
      run_open(32'h0A00_0020, 16'd2000, 0, 0);
      n_tests++;
      if (active_cnt !== 7'd3 || !model_alloc[1]) begin
         n_fail++;
         $display("FAIL reuse_cnt: active_cnt=%0d required 3", active_cnt);
      end
      run_open(32'h0A00_0021, 16'd2001, 1, 2);
   endtask

   task automatic test_mismatch_reset();
      bit got;
      apply_reset();
      m_open_rsp_ready = 1'b0;
      accept_open(32'h0A00_0005, 16'd5000, got);
      tick();
      tick();
      s_est_valid   = 1'b1;
      s_est_sid     = 6'd5;
      s_est_success = 1'b1;
      tick();
      s_est_valid = 1'b0;
      n_tests++;
      if (!got || m_open_rsp_valid !== 1'b0 || s_est_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mismatch_drop: rsp_valid=%0d est_ready=%0d required 0 1",
                  m_open_rsp_valid, s_est_ready);
      end
      s_est_valid = 1'b1;
      s_est_sid   = 6'd0;
      tick();
      s_est_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (m_open_rsp_valid !== 1'b1 || m_open_rsp_sid !== 6'd0 || m_open_rsp_success !== 1'b1)
         begin
            n_fail++;
            $display("FAIL rsp_hold cycle %0d: valid=%0d sid=%0d ok=%0d required 1 0 1", k,
                     m_open_rsp_valid, m_open_rsp_sid, m_open_rsp_success);
         end
         tick();
      end
      #3;
      aresetn = 1'b0;
      #1;
      n_tests++;
      if (!outputs_zero()) begin
         n_fail++;
         $display("FAIL mid_rsp_reset: rsp_valid=%0d active_cnt=%0d required 0 0",
                  m_open_rsp_valid, active_cnt);
      end
      m_open_rsp_ready = 1'b1;
      model_clear();
      @(negedge aclk);
      aresetn = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (m_open_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_rsp_after_reset: rsp_valid=%0d required 0", m_open_rsp_valid);
         end
         tick();
      end
   endtask

   task automatic test_random_mix();
      apply_reset();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) run_close(int'($urandom_range(0, 7)));
         else run_open($urandom, 16'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic_open();
      test_close_priority();
      test_reuse();
      test_timeout();
      test_mismatch_reset();
      test_pool_full();
      test_random_mix();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
